// File: rtl/leg_pkg.sv
// Shared definitions for LEG instruction-word builders: mode codes, word size, byte index.
package leg_pkg;

  // opcode[7:6] codes selected by the one-hot mode select
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_1    = 2'b01;
  localparam logic [1:0] MODE_2    = 2'b10;
  localparam logic [1:0] MODE_3    = 2'b11;

  localparam int unsigned LEG_WORD_BYTES = 4;

  // Byte position within the LEG word {opcode, arg1, arg2, dest}
  typedef enum logic [1:0] {
    ByteOp   = 2'd0,
    ByteArg1 = 2'd1,
    ByteArg2 = 2'd2,
    ByteDest = 2'd3
  } byte_idx_e;

  typedef enum logic {
    StIdle,
    StEmit
  } enc_state_e;

  // Assemble the opcode byte from the mode code and the pass-through low bits
  function automatic logic [7:0] pack_opcode(input logic [1:0] mode, input logic [5:0] op_lo);
    return {mode, op_lo};
  endfunction

endpackage

// File: rtl/leg_mode_encoder.sv
// One-hot mode select to 2-bit opcode mode code; highest set bit wins and multi-hot is flagged.
module leg_mode_encoder
  import leg_pkg::*;
(
  input  logic [2:0] mode_sel,
  output logic [1:0] mode_code,
  output logic       multi_hot
);

  // Priority encode so a permissive caller gets a deterministic code on multi-hot input
  always_comb begin
    mode_code = MODE_NONE;
    if (mode_sel[2]) begin
      mode_code = MODE_3;
    end else if (mode_sel[1]) begin
      mode_code = MODE_2;
    end else if (mode_sel[0]) begin
      mode_code = MODE_1;
    end
    multi_hot = (mode_sel[0] & mode_sel[1]) | (mode_sel[0] & mode_sel[2]) |
                (mode_sel[1] & mode_sel[2]);
  end

endmodule

// File: rtl/leg_opcode_encoder.sv
// Packs one LEG command into {opcode, arg1, arg2, dest} and streams it byte-serially to
// program RAM at an auto-incrementing, wrapping write pointer.
module leg_opcode_encoder
  import leg_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter bit                STRICT_OH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        mode_sel,
  input  logic [5:0]        op_lo,
  input  logic [7:0]        arg1,
  input  logic [7:0]        arg2,
  input  logic [7:0]        dest,
  input  logic              ptr_load,
  input  logic [ADDR_W-1:0] ptr_val,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              done,
  output logic              err
);

  enc_state_e                         state_q, state_d;
  byte_idx_e                          idx_q;
  logic [LEG_WORD_BYTES-1:0][7:0]     word_q;
  logic [ADDR_W-1:0]                  wr_ptr_q;
  logic                               started_q;
  logic                               done_q;
  logic                               err_q;

  logic [1:0] mode_code;
  logic       multi_hot;
  logic       handshake;
  logic       reject;
  logic       accept;
  logic       byte_xfer;
  logic       last_xfer;

  leg_mode_encoder u_mode_enc (
    .mode_sel  (mode_sel),
    .mode_code (mode_code),
    .multi_hot (multi_hot)
  );

  // Command and memory-transfer qualifiers
  always_comb begin
    handshake = cmd_valid & cmd_ready;
    reject    = handshake & STRICT_OH & multi_hot;
    accept    = handshake & ~reject;
    byte_xfer = (state_q == StEmit) & mem_ready;
    last_xfer = byte_xfer & (idx_q == ByteDest);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)    state_d = StEmit;
      StEmit: if (last_xfer) state_d = StIdle;
      default:               state_d = StIdle;
    endcase
  end

  // Outputs; cmd_ready stays low for the first cycle out of reset and whenever a pointer load
  // is requested, so a load always wins over a simultaneous command
  always_comb begin
    cmd_ready = (state_q == StIdle) & started_q & ~ptr_load;
    mem_we    = (state_q == StEmit);
    mem_addr  = wr_ptr_q;
    mem_data  = mem_we ? word_q[idx_q] : 8'h00;
    wr_ptr    = wr_ptr_q;
    done      = done_q;
    err       = err_q;
  end

  // Word capture, byte index, write pointer and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      word_q    <= '0;
      idx_q     <= ByteOp;
      wr_ptr_q  <= BASE_ADDR;
    end else begin
      started_q <= 1'b1;
      done_q    <= last_xfer;
      err_q     <= reject;
      if (accept) begin
        word_q <= {dest, arg2, arg1, pack_opcode(mode_code, op_lo)};
        idx_q  <= ByteOp;
      end else if (byte_xfer) begin
        idx_q <= byte_idx_e'(idx_q + 2'd1);
      end
      if (byte_xfer) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end else if ((state_q == StIdle) && ptr_load) begin
        wr_ptr_q <= ptr_val;
      end
    end
  end

endmodule

// File: tb/tb_leg_opcode_encoder.sv
// Bench for leg_opcode_encoder: directed commands feed an expected-write queue that a
// negedge monitor drains against the memory port.
module tb_leg_opcode_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_valid_ns = 1'b0;
  logic [2:0] mode_sel = '0;
  logic [5:0] op_lo = '0;
  logic [7:0] arg1 = '0, arg2 = '0, dest = '0;
  logic       ptr_load = 1'b0;
  logic [7:0] ptr_val = '0;
  logic       mem_ready = 1'b1;

  logic       cmd_ready, mem_we, done, err;
  logic [7:0] mem_addr, mem_data, wr_ptr;
  logic       cmd_ready_ns, mem_we_ns, done_ns, err_ns;
  logic [7:0] mem_addr_ns, mem_data_ns, wr_ptr_ns;

  always #5 clk = ~clk;

  leg_opcode_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00), .STRICT_OH(1'b1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mode_sel(mode_sel), .op_lo(op_lo), .arg1(arg1), .arg2(arg2), .dest(dest),
    .ptr_load(ptr_load), .ptr_val(ptr_val), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .wr_ptr(wr_ptr), .done(done), .err(err)
  );

  leg_opcode_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00), .STRICT_OH(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_ns), .cmd_ready(cmd_ready_ns),
    .mode_sel(mode_sel), .op_lo(op_lo), .arg1(arg1), .arg2(arg2), .dest(dest),
    .ptr_load(ptr_load), .ptr_val(ptr_val), .mem_we(mem_we_ns), .mem_ready(mem_ready),
    .mem_addr(mem_addr_ns), .mem_data(mem_data_ns), .wr_ptr(wr_ptr_ns), .done(done_ns),
    .err(err_ns)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         n_cmp = 0;
  int         n_fail = 0;
  logic [7:0] model_ptr = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted memory byte must match the head of the expected queue
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 mem_addr, mem_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", mem_addr, mon_e.addr);
        check("wr_data", mem_data, mon_e.data);
      end
    end
    if (done || err) check("done_err_exclusive", done & err, 0);
  end

  // Issue one command to the strict instance and check latency, stalls and pointer
  task automatic issue(input logic [2:0] ms, input logic [5:0] op, input logic [7:0] a1,
                       input logic [7:0] a2, input logic [7:0] d, input logic [7:0] opc,
                       input bit exp_err, input int stall_idx, input int stall_n);
    logic [7:0] bytes[4];
    wr_t        w;
    int         seen;
    bit         got;
    bytes = '{opc, a1, a2, d};
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) begin
        w.addr = model_ptr + 8'(i);
        w.data = bytes[i];
        exp_q.push_back(w);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    mode_sel  = ms;
    op_lo     = op;
    arg1      = a1;
    arg2      = a2;
    dest      = d;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (cmd_ready) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: got cmd_ready=0 for 20 cycles, expected 1");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (exp_err) begin
      @(negedge clk);
      check("err_pulse", err, 1);
      check("err_no_write", mem_we, 0);
      check("err_wr_ptr", wr_ptr, model_ptr);
      return;
    end
    seen = -1;
    for (int j = 0; j < 4 + stall_n + 6 && seen < 0; j++) begin
      mem_ready = !(j >= stall_idx && j < stall_idx + stall_n);
      @(negedge clk);
      if (!mem_ready) begin
        check("stall_addr", mem_addr, model_ptr + 8'(stall_idx));
        check("stall_data", mem_data, bytes[stall_idx]);
      end
      if (done) seen = j;
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b1;
    check("done_latency", seen, 4 + stall_n);
    model_ptr = model_ptr + 8'd4;
    check("wr_ptr_after", wr_ptr, model_ptr);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no $finish by 50000, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    // Reset values while held in reset
    #12;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_data", mem_data, 8'h00);
    check("rst_wr_ptr", wr_ptr, 8'h00);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("ready_before_first_clk", cmd_ready, 0);

    // Basic word and the three other mode codes
    issue(3'b001, 6'h05, 8'h11, 8'h22, 8'h33, 8'h45, 1'b0, 0, 0);
    issue(3'b000, 6'h3F, 8'h01, 8'h02, 8'h03, 8'h3F, 1'b0, 0, 0);
    issue(3'b010, 6'h3F, 8'h04, 8'h05, 8'h06, 8'hBF, 1'b0, 0, 0);
    issue(3'b100, 6'h3F, 8'h07, 8'h08, 8'h09, 8'hFF, 1'b0, 0, 0);

    // Multi-hot rejected by the strict instance
    issue(3'b011, 6'h3F, 8'hAA, 8'hBB, 8'hCC, 8'h00, 1'b1, 0, 0);

    // Permissive instance: highest bit wins on multi-hot
    @(negedge clk);
    cmd_valid_ns = 1'b1;
    mode_sel = 3'b011;
    op_lo = 6'h3F;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (cmd_ready_ns) got = 1'b1;
      else @(negedge clk);
    end
    check("ns_handshake", got, 1);
    @(posedge clk);
    #1 cmd_valid_ns = 1'b0;
    @(negedge clk);
    check("ns_mem_we", mem_we_ns, 1);
    check("ns_mem_addr", mem_addr_ns, 8'h00);
    check("ns_opcode", mem_data_ns, 8'hBF);
    check("ns_no_err", err_ns, 0);
    repeat (6) @(negedge clk);
    check("ns_wr_ptr", wr_ptr_ns, 8'h04);

    // Pointer load beats a simultaneous command, then a word straddling the wrap
    @(negedge clk);
    ptr_load = 1'b1;
    ptr_val = 8'hFE;
    cmd_valid = 1'b1;
    mode_sel = 3'b001;
    #1 check("ptr_load_blocks_ready", cmd_ready, 0);
    @(posedge clk);
    #1;
    ptr_load = 1'b0;
    cmd_valid = 1'b0;
    check("ptr_loaded", wr_ptr, 8'hFE);
    model_ptr = 8'hFE;
    issue(3'b100, 6'h01, 8'h5A, 8'h5B, 8'h5C, 8'hC1, 1'b0, 0, 0);

    // Three-cycle stall on byte 2
    issue(3'b010, 6'h12, 8'h61, 8'h62, 8'h63, 8'h92, 1'b0, 2, 3);

    // Reset after byte 1 has transferred
    begin
      wr_t w;
      w.addr = model_ptr;
      w.data = 8'h6A;
      exp_q.push_back(w);
      w.addr = model_ptr + 8'd1;
      w.data = 8'hA1;
      exp_q.push_back(w);
    end
    @(negedge clk);
    cmd_valid = 1'b1;
    mode_sel = 3'b001;
    op_lo = 6'h2A;
    arg1 = 8'hA1;
    arg2 = 8'hA2;
    dest = 8'hA3;
    check("pre_rst_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 8'h00);
    check("midrst_mem_data", mem_data, 8'h00);
    check("midrst_wr_ptr", wr_ptr, 8'h00);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("midrst_ready_after_release", cmd_ready, 0);
    model_ptr = 8'h00;
    issue(3'b000, 6'h00, 8'hDE, 8'hAD, 8'hBE, 8'h00, 1'b0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
